// File: rtl/zps2_key_decoder_if.sv
// PS/2 line and decoded-key bundle shared by the PS/2 key decoder and its driver.
// The master drives the raw PS/2 lines, and the slave (the decoder) drives the key levels and strobes.
interface zps2_key_decoder_if;
  logic       iPS2Clk;
  logic       iPS2Data;
  logic       o1;
  logic       o2;
  logic       oEnter;
  logic [7:0] oByte;
  logic       oByteValid;
  logic       oFrameErr;

  modport master (
    output iPS2Clk, iPS2Data,
    input  o1, o2, oEnter, oByte, oByteValid, oFrameErr
  );

  modport slave (
    input  iPS2Clk, iPS2Data,
    output o1, o2, oEnter, oByte, oByteValid, oFrameErr
  );
endinterface

// File: rtl/zps2_key_decoder.sv
// PS/2 scan-code-set-2 receiver. It turns the make/break sequences for '1', '2' and
// Enter into held-key levels that feed the main-menu FSM.
module zps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 iReset,
  zps2_key_decoder_if.slave    bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  function automatic logic odd_parity(input logic [8:0] v);
    return ^v;
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;
  logic                   fall_s;

  state_t                 state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   done_s, ok_s, tmo_err_s;

  logic [7:0]             byte_q;
  logic                   valid_q, err_q;
  logic                   brk_q, brk_d, ext_q, ext_d;
  logic                   k1_q, k1_d, k2_q, k2_d, ke_q, ke_d;

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  assign fall_s     = clk_prev_q & ~ps2_clk_s;

  // Synchronise the PS/2 lines and keep the previous clock level for edge detection.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      clk_sync_q  <= {SYNC_STAGES{1'b1}};
      data_sync_q <= {SYNC_STAGES{1'b1}};
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.iPS2Clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.iPS2Data};
      clk_prev_q  <= ps2_clk_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
    end
  end

  // Receiver next state, frame check and mid-frame timeout.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    done_s    = 1'b0;
    ok_s      = 1'b0;
    tmo_err_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall_s && !ps2_data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_d = {ps2_data_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          parity_d = ps2_data_s;
          state_d  = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_d = ST_IDLE;
          done_s  = 1'b1;
          ok_s    = odd_parity({parity_q, shift_q}) & ps2_data_s;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A falling edge restarts the timeout window; the counter rests at zero in IDLE.
    if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (fall_s) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_d     = '0;
      state_d   = ST_IDLE;
      tmo_err_s = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Byte and strobe outputs, registered one cycle after the stop edge.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      byte_q  <= (done_s && ok_s) ? shift_q : byte_q;
      valid_q <= done_s & ok_s;
      err_q   <= (done_s & ~ok_s) | tmo_err_s;
    end
  end

  // Make/break decoder next state, acting on each valid byte or frame error.
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    k1_d  = k1_q;
    k2_d  = k2_q;
    ke_d  = ke_q;
    if (valid_q) begin
      case (byte_q)
        8'hE0:   ext_d = 1'b1;
        8'hF0:   brk_d = 1'b1;
        default: begin
          if (!ext_q) begin
            case (byte_q)
              8'h16:   k1_d = ~brk_q;
              8'h1E:   k2_d = ~brk_q;
              8'h5A:   ke_d = ~brk_q;
              default: k1_d = k1_q;
            endcase
          end else begin
            k1_d = k1_q;
          end
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
      endcase
    end else if (err_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else begin
      brk_d = brk_q;
    end
  end

  // Decoder flag and key-level registers.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      k1_q  <= 1'b0;
      k2_q  <= 1'b0;
      ke_q  <= 1'b0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      k1_q  <= k1_d;
      k2_q  <= k2_d;
      ke_q  <= ke_d;
    end
  end

  assign bus.o1         = k1_q;
  assign bus.o2         = k2_q;
  assign bus.oEnter     = ke_q;
  assign bus.oByte      = byte_q;
  assign bus.oByteValid = valid_q;
  assign bus.oFrameErr  = err_q;

endmodule

// File: tb/tb_zps2_key_decoder.sv
// Self-checking bench for zps2_key_decoder. It runs directed PS/2 frame sequences and then
// random ones, and compares the DUT against a scan-code-level model of the key state.
module tb_zps2_key_decoder;
  localparam int HALF = 50;
  localparam int TMO  = 10000;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  zps2_key_decoder_if bus();

  zps2_key_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .iReset (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;
  logic [7:0] mon_byte = 8'h00;

  int exp_v = 0;
  int exp_e = 0;
  logic [7:0] exp_byte = 8'h00;
  bit m_brk = 0, m_ext = 0, m1 = 0, m2 = 0, me = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.oByteValid) begin
        vcnt++;
        mon_byte = bus.oByte;
      end
      if (bus.oFrameErr) ecnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic edge_bit(input bit d);
    cyc(HALF / 2);
    bus.iPS2Data = d;
    cyc(HALF / 2);
    bus.iPS2Clk = 1'b0;
  endtask

  task automatic rise();
    cyc(HALF);
    bus.iPS2Clk = 1'b1;
  endtask

  // Drives a whole frame and returns just after the stop-bit falling edge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      edge_bit(f[i]);
      if (i < 10) rise();
    end
  endtask

  // Reference behaviour: a received byte (or frame error) updates the held-key picture.
  task automatic model(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_e++;
      m_brk = 0;
      m_ext = 0;
    end else begin
      exp_v++;
      exp_byte = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        if (!m_ext) begin
          if (b == 8'h16) m1 = !m_brk;
          if (b == 8'h1E) m2 = !m_brk;
          if (b == 8'h5A) me = !m_brk;
        end
        m_brk = 0;
        m_ext = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valids"}, vcnt, exp_v);
    chk({tag, "_errs"}, ecnt, exp_e);
    chk({tag, "_byte"}, bus.oByte, exp_byte);
    chk({tag, "_o1"}, bus.o1, m1);
    chk({tag, "_o2"}, bus.o2, m2);
    chk({tag, "_enter"}, bus.oEnter, me);
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input bit bad);
    send_frame(b, bad);
    rise();
    model(b, !bad);
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_o1"}, bus.o1, 0);
    chk({tag, "_o2"}, bus.o2, 0);
    chk({tag, "_enter"}, bus.oEnter, 0);
    chk({tag, "_byte"}, bus.oByte, 0);
    chk({tag, "_bv"}, bus.oByteValid, 0);
    chk({tag, "_fe"}, bus.oFrameErr, 0);
  endtask

  initial begin
    int k;
    int first;
    int pulses;
    logic [7:0] codes [8];
    logic [7:0] rb;
    bit rbad;

    rst = 1'b1;
    bus.iPS2Clk = 1'b1;
    bus.iPS2Data = 1'b1;
    cyc(5);
    check_zero("reset");
    rst = 1'b0;
    cyc(5);

    // Make '1' with strobe latency and one-cycle width
    send_frame(8'h16, 0);
    k = 21;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.oByteValid) begin
        k = n;
        break;
      end
    end
    chk("lat_valid", k, 4);
    chk("lat_o1_before", bus.o1, 0);
    @(negedge clk);
    chk("lat_o1_after", bus.o1, 1);
    chk("lat_valid_width", bus.oByteValid, 0);
    rise();
    model(8'h16, 1);
    check_all("make1");

    frame("brk_f0", 8'hF0, 0);
    frame("brk_16", 8'h16, 0);

    frame("ext_e0a", 8'hE0, 0);
    frame("ext_5a", 8'h5A, 0);
    frame("ext_e0b", 8'hE0, 0);
    frame("ext_f0", 8'hF0, 0);
    frame("ext_5ab", 8'h5A, 0);
    frame("plain_5a", 8'h5A, 0);

    frame("badpar_1e", 8'h1E, 1);
    frame("good_1e", 8'h1E, 0);

    // Timeout after a start bit and three data bits
    edge_bit(0);
    rise();
    edge_bit(0);
    rise();
    edge_bit(1);
    rise();
    edge_bit(1);
    first = 0;
    pulses = 0;
    for (int n = 1; n <= 12000; n++) begin
      @(negedge clk);
      if (n == HALF) bus.iPS2Clk = 1'b1;
      if (bus.oFrameErr) begin
        if (first == 0) first = n;
        pulses++;
      end
    end
    chk("tmo_window", (first >= TMO && first <= TMO + 8), 1);
    chk("tmo_pulses", pulses, 1);
    cyc(1);
    model(8'h00, 0);
    check_all("tmo");
    frame("post_tmo_16", 8'h16, 0);

    // Asynchronous reset in the middle of a frame while '1' is held
    chk("pre_rst_o1", bus.o1, 1);
    edge_bit(0);
    rise();
    edge_bit(1);
    cyc(3);
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    bus.iPS2Clk = 1'b1;
    bus.iPS2Data = 1'b1;
    cyc(10);
    rst = 1'b0;
    m1 = 0; m2 = 0; me = 0; m_brk = 0; m_ext = 0;
    exp_byte = 8'h00;
    cyc(10);
    check_all("post_rst");
    frame("rst_f0", 8'hF0, 0);
    frame("rst_16", 8'h16, 0);

    // Random frames drawn from known and arbitrary codes, some with bad parity
    codes[0] = 8'h16; codes[1] = 8'h1E; codes[2] = 8'h5A; codes[3] = 8'hE0;
    codes[4] = 8'hF0; codes[5] = 8'hAA; codes[6] = 8'hFA; codes[7] = 8'h00;
    for (int r = 0; r < 20; r++) begin
      k = $urandom_range(0, 7);
      rb = (k == 7) ? 8'($urandom_range(0, 255)) : codes[k];
      rbad = ($urandom_range(0, 5) == 0);
      frame("rand", rb, rbad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
